// File: rtl/adc_ltc2308_sampler_pkg.sv
// Shared types and constants for the LTC2308 sampler: word widths, the
// sequencer state encoding and the ADC configuration-word builder.
package adc_pkg;

  localparam int ADC_BITS  = 12;
  localparam int CFG_BITS  = 6;
  // Every ADC data bit needs one low and one high SCK phase.
  localparam int SHIFT_CYC = 2 * ADC_BITS;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT,
    SHIFT,
    DONE
  } adc_state_e;

  // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, no sleep.
  function automatic logic [CFG_BITS-1:0] make_cfg(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/adc_ltc2308_sampler_if.sv
// Sample stream from the LTC2308 sampler towards the FFT stage.
// master = sampler (drives), slave = consumer.
interface adc_ltc2308_sampler_if;
  import adc_pkg::*;

  logic [ADC_BITS-1:0] sample;
  logic [2:0]          sample_ch;
  logic                sample_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output sample,
    output sample_ch,
    output sample_valid,
    output busy,
    output overrun
  );

  modport slave (
    input sample,
    input sample_ch,
    input sample_valid,
    input busy,
    input overrun
  );

endinterface

// File: rtl/adc_ltc2308_sampler_rate_tick.sv
// Sample-rate divider: counts 0..TICK_DIV-1 and flags the last count, so
// the first tick appears TICK_DIV cycles after reset release.
module adc_rate_tick #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: wrap after the last value.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here via
    // the ternary); a missing branch would infer a latch.
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/adc_ltc2308_sampler.sv
// LTC2308 serial ADC sampler. Every sample tick it pulses CONVST, waits out
// the conversion, then clocks 12 result bits in on SDO while sending the
// next 6-bit config word on SDI. The ADC returns the conversion selected by
// the previous frame's config, so sample_ch reports the previous channel
// and the first frame after reset produces no sample.
// Build option: define ADC_TEST_RAMP_EN to replace the captured value with
// a 12-bit test ramp (pin sequencing unchanged).
module adc_ltc2308_sampler
  import adc_pkg::*;
#(
  parameter int FCLK       = 50_000_000,
  parameter int FS         = 48_000,
  parameter int CONVST_CYC = 2,
  parameter int TCONV_CYC  = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            ADC_channel,
  input  logic                  ADC_SDO,
  output logic                  ADC_CONVST,
  output logic                  ADC_SCK,
  output logic                  ADC_SDI,
  adc_ltc2308_sampler_if.master out_if
);

  localparam int TICK_DIV = FCLK / FS;
  localparam int CNT_W    = $clog2(CONVST_CYC + TCONV_CYC + SHIFT_CYC + 1);

  // A full frame must fit inside one sample period.
  if (TICK_DIV < CONVST_CYC + TCONV_CYC + 26) begin : g_tick_div_check
    $fatal(1, "adc_ltc2308_sampler: TICK_DIV %0d too small for one frame", TICK_DIV);
  end

  logic tick;

  adc_rate_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_rate_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic [CFG_BITS-1:0] cfg_new;
  assign cfg_new = make_cfg(ADC_channel);

  adc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 convst_q, convst_d;
  logic                 sck_q, sck_d;
  logic                 sdi_q, sdi_d;
  // Config bits still to be sent after the one currently on SDI.
  logic [CFG_BITS-2:0]  cfg_sr_q, cfg_sr_d;
  logic [ADC_BITS-1:0]  cap_q, cap_d;
  logic [2:0]           ch_q, ch_d;
  logic [2:0]           prev_ch_q, prev_ch_d;
  logic                 first_q, first_d;
  logic [ADC_BITS-1:0]  sample_q, sample_d;
  logic [2:0]           sample_ch_q, sample_ch_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
`ifdef ADC_TEST_RAMP_EN
  logic [ADC_BITS-1:0]  ramp_q, ramp_d;
`endif

  // Frame sequencer next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    convst_d    = convst_q;
    sck_d       = sck_q;
    sdi_d       = sdi_q;
    cfg_sr_d    = cfg_sr_q;
    cap_d       = cap_q;
    ch_d        = ch_q;
    prev_ch_d   = prev_ch_q;
    first_d     = first_q;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    valid_d     = 1'b0;
    // A tick while a frame is running is dropped and flagged.
    overrun_d   = tick && (state_q != IDLE);
`ifdef ADC_TEST_RAMP_EN
    ramp_d      = ramp_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          ch_d      = ADC_channel;
          prev_ch_d = ch_q;
          sdi_d     = cfg_new[CFG_BITS-1];
          cfg_sr_d  = cfg_new[CFG_BITS-2:0];
          convst_d  = 1'b1;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end

      CONV: begin
        if (cnt_q == CNT_W'(CONVST_CYC - 1)) begin
          convst_d = 1'b0;
          cnt_d    = '0;
          state_d  = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT: begin
        if (cnt_q == CNT_W'(TCONV_CYC - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        sck_d = ~sck_q;
        if (!sck_q) begin
          // SCK about to rise: the ADC holds the current bit on SDO.
          cap_d = {cap_q[ADC_BITS-2:0], ADC_SDO};
        end else begin
          // SCK about to fall: present the next config bit; zeros follow
          // once all six have gone out.
          sdi_d    = cfg_sr_q[CFG_BITS-2];
          cfg_sr_d = {cfg_sr_q[CFG_BITS-3:0], 1'b0};
        end
        if (cnt_q == CNT_W'(SHIFT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        sck_d = 1'b0;
        sdi_d = 1'b0;
        if (!first_q) begin
`ifdef ADC_TEST_RAMP_EN
          sample_d = ramp_q;
          ramp_d   = ramp_q + 1'b1;
`else
          sample_d = cap_q;
`endif
          sample_ch_d = prev_ch_q;
          valid_d     = 1'b1;
        end
        first_d = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs; reset idles the ADC pins at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      convst_q    <= 1'b0;
      sck_q       <= 1'b0;
      sdi_q       <= 1'b0;
      cfg_sr_q    <= '0;
      cap_q       <= '0;
      ch_q        <= '0;
      prev_ch_q   <= '0;
      first_q     <= 1'b1;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ADC_TEST_RAMP_EN
      ramp_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      convst_q    <= convst_d;
      sck_q       <= sck_d;
      sdi_q       <= sdi_d;
      cfg_sr_q    <= cfg_sr_d;
      cap_q       <= cap_d;
      ch_q        <= ch_d;
      prev_ch_q   <= prev_ch_d;
      first_q     <= first_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef ADC_TEST_RAMP_EN
      ramp_q      <= ramp_d;
`endif
    end
  end

  assign ADC_CONVST          = convst_q;
  assign ADC_SCK             = sck_q;
  assign ADC_SDI             = sdi_q;
  assign out_if.sample       = sample_q;
  assign out_if.sample_ch    = sample_ch_q;
  assign out_if.sample_valid = valid_q;
  assign out_if.busy         = (state_q != IDLE);
  assign out_if.overrun      = overrun_q;

endmodule
